// File: rtl/demux_collect_1024_if.sv
// demux_collect_1024_if: serial-in / folded-word-out handshake bundle for demux_collect_1024.
interface demux_collect_1024_if #(parameter int IDX_W = 10, parameter int OUT_W = 1000);
  logic start;
  logic [IDX_W-1:0] start_idx;
  logic [2:0] com_sel;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic [OUT_W-1:0] word_out;
  logic word_valid;
  logic word_ready;
  logic busy;
  logic parity_err;
  modport master (
    output start, start_idx, com_sel, bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_valid, busy, parity_err
  );
  modport slave (
    input  start, start_idx, com_sel, bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_valid, busy, parity_err
  );
endinterface

// File: rtl/demux_collect_1024.sv
// demux_collect_1024: scatters a serial bit stream into a scrambled WIDTH-bit shadow and emits it folded to OUT_W bits.
// Optional trailing even-parity bit when DEMUX_COLLECT_PARITY_EN is defined.
module demux_collect_1024 #(
  parameter int WIDTH = 1024,
  parameter int IDX_W = 10,
  parameter int OUT_W = 1000
) (
  input logic clk,
  input logic rst_n,
  demux_collect_1024_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, PAR, HOLD} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [IDX_W-1:0] cnt, base, idx;
  logic [2:0] scr;
  logic [OUT_W-1:0] word_out, fold;
  logic beat, fill_beat, last;
  assign beat = bus.bit_valid && (state == FILL || state == PAR);
  assign fill_beat = beat && state == FILL;
  assign last = fill_beat && cnt == IDX_W'(WIDTH - 1);
  assign idx = (base + cnt) ^ {{(IDX_W-3){1'b0}}, scr};
  // Fold sees the beat landing on this edge so the final data bit reaches word_out.
  always_comb begin
    shadow_nxt = shadow;
    if (fill_beat) shadow_nxt[idx] = bus.bit_in;
  end
  assign fold = shadow_nxt[OUT_W-1:0] ^ {{(2*OUT_W-WIDTH){1'b0}}, shadow_nxt[WIDTH-1:OUT_W]};
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = FILL;
`ifdef DEMUX_COLLECT_PARITY_EN
      FILL: if (last) state_nxt = PAR;
      PAR:  if (beat) state_nxt = HOLD;
`else
      FILL: if (last) state_nxt = HOLD;
`endif
      HOLD: if (bus.word_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shadow <= '0;
      cnt <= '0;
      base <= '0;
      scr <= '0;
      word_out <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        shadow <= '0;
        cnt <= '0;
        base <= bus.start_idx;
        scr <= bus.com_sel;
      end else if (fill_beat) begin
        shadow <= shadow_nxt;
        cnt <= cnt + IDX_W'(1);
      end
      if (state != HOLD && state_nxt == HOLD) word_out <= fold;
    end
  end
`ifdef DEMUX_COLLECT_PARITY_EN
  logic par, parity_err;
  // Running XOR over accepted beats; the PAR beat closes it on the edge into HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
      parity_err <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      par <= 1'b0;
      parity_err <= 1'b0;
    end else if (beat) begin
      par <= par ^ bus.bit_in;
      if (state == PAR) parity_err <= par ^ bus.bit_in;
    end
  end
  assign bus.parity_err = parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.bit_ready = state == FILL || state == PAR;
  assign bus.word_valid = state == HOLD;
  assign bus.busy = state != IDLE;
  assign bus.word_out = word_out;
endmodule
